// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and access checking.
package lsu_pkg;

  localparam logic [2:0] F3Byte   = 3'b000;
  localparam logic [2:0] F3Half   = 3'b001;
  localparam logic [2:0] F3Word   = 3'b010;
  localparam logic [2:0] F3ByteU  = 3'b100;
  localparam logic [2:0] F3HalfU  = 3'b101;

  typedef enum logic [0:0] {StIdle, StRmwWr} lsu_state_e;

  // Misaligned offset or an encoding that is not legal for the access direction.
  function automatic logic access_err(logic we, logic [2:0] funct3, logic [1:0] off);
    logic err;
    case (funct3)
      F3Byte:  err = 1'b0;
      F3Half:  err = off[0];
      F3Word:  err = (off != 2'b00);
      F3ByteU: err = we;
      F3HalfU: err = we | off[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [2:0]       funct3_i,
  input  logic [1:0]       byte_off_i,
  input  logic [Width-1:0] rdata_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] load_data_o,
  output logic [Width-1:0] merged_o
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = rdata_i[{byte_off_i, 3'b000} +: 8];
    half_val = rdata_i[{byte_off_i[1], 4'b0000} +: 16];

    case (funct3_i)
      F3Byte:  load_data_o = {{(Width-8){byte_val[7]}}, byte_val};
      F3Half:  load_data_o = {{(Width-16){half_val[15]}}, half_val};
      F3ByteU: load_data_o = {{(Width-8){1'b0}}, byte_val};
      F3HalfU: load_data_o = {{(Width-16){1'b0}}, half_val};
      default: load_data_o = rdata_i;
    endcase

    merged_o = rdata_i;
    if (funct3_i[1:0] == 2'b00) begin
      merged_o[{byte_off_i, 3'b000} +: 8] = wdata_i[7:0];
    end else if (funct3_i[1:0] == 2'b01) begin
      merged_o[{byte_off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: single-cycle loads and word stores, two-cycle read-modify-write
// for byte/half stores against a word-wide memory with combinational read.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned Width     = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [2:0]           req_funct3_i,
  input  logic [31:0]          req_addr_i,
  input  logic [Width-1:0]     req_wdata_i,
  output logic                 resp_valid_o,
  output logic [Width-1:0]     resp_rdata_o,
  output logic                 resp_err_o,
  output logic                 mem_write_en_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [Width-1:0]     mem_write_data_o,
  input  logic [Width-1:0]     mem_read_data_i
);

  lsu_state_e           state_q, state_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_err_q, resp_err_d;
  logic [Width-1:0]     resp_rdata_q, resp_rdata_d;
  logic [Width-1:0]     merged_q, merged_d;
  logic [AddrWidth-1:0] addr_q, addr_d;

  logic                 accept, err, is_sw;
  logic [AddrWidth-1:0] req_word;
  logic [Width-1:0]     load_data, merged;

  // Address bits above the memory window wrap and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr_i[31:AddrWidth+2];

  assign req_word    = req_addr_i[AddrWidth+1:2];
  assign req_ready_o = (state_q == StIdle);
  assign accept      = req_valid_i & req_ready_o;
  assign err         = access_err(req_we_i, req_funct3_i, req_addr_i[1:0]);
  assign is_sw       = req_we_i & (req_funct3_i == F3Word);

  lsu_align #(
    .Width(Width)
  ) u_align (
    .funct3_i   (req_funct3_i),
    .byte_off_i (req_addr_i[1:0]),
    .rdata_i    (mem_read_data_i),
    .wdata_i    (req_wdata_i),
    .load_data_o(load_data),
    .merged_o   (merged)
  );

  always_comb begin
    mem_addr_o       = (state_q == StRmwWr) ? addr_q : req_word;
    mem_write_data_o = (state_q == StRmwWr) ? merged_q : req_wdata_i;
    mem_write_en_o   = (state_q == StRmwWr) | (accept & is_sw & ~err);
  end

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    merged_d     = merged_q;
    addr_d       = addr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_we_i) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data;
          end else if (is_sw) begin
            resp_valid_d = 1'b1;
          end else begin
            state_d  = StRmwWr;
            merged_d = merged;
            addr_d   = req_word;
          end
        end
      end
      StRmwWr: begin
        state_d      = StIdle;
        resp_valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      merged_q     <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      merged_q     <= merged_d;
      addr_q       <= addr_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_write_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_write_data, mem_read_data;

  logic [31:0] mem [256];

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  assign mem_read_data = mem[mem_addr];
  always @(posedge clk_i) if (mem_write_en) mem[mem_addr] <= mem_write_data;

  load_store_unit dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_we_i        (req_we),
    .req_funct3_i    (req_funct3),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .resp_valid_o    (resp_valid),
    .resp_rdata_o    (resp_rdata),
    .resp_err_o      (resp_err),
    .mem_write_en_o  (mem_write_en),
    .mem_addr_o      (mem_addr),
    .mem_write_data_o(mem_write_data),
    .mem_read_data_i (mem_read_data)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_wen;
    logic [7:0]  exp_maddr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NumVecs = 18;
  vec_t vecs [NumVecs];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h8070_F0A5;
    mem[1] = 32'hAABB_CCDD;

    //          we  f3      addr          wdata         wen maddr  rdata         err
    vecs[0]  = '{0, 3'b000, 32'h0000_0000, 32'h0,         0, 8'h00, 32'hFFFF_FFA5, 0};
    vecs[1]  = '{0, 3'b100, 32'h0000_0001, 32'h0,         0, 8'h00, 32'h0000_00F0, 0};
    vecs[2]  = '{0, 3'b001, 32'h0000_0002, 32'h0,         0, 8'h00, 32'hFFFF_8070, 0};
    vecs[3]  = '{0, 3'b101, 32'h0000_0002, 32'h0,         0, 8'h00, 32'h0000_8070, 0};
    vecs[4]  = '{0, 3'b001, 32'h0000_0000, 32'h0,         0, 8'h00, 32'hFFFF_F0A5, 0};
    vecs[5]  = '{0, 3'b000, 32'h0000_0003, 32'h0,         0, 8'h00, 32'hFFFF_FF80, 0};
    vecs[6]  = '{0, 3'b100, 32'h0000_0002, 32'h0,         0, 8'h00, 32'h0000_0070, 0};
    vecs[7]  = '{0, 3'b010, 32'h0000_0004, 32'h0,         0, 8'h01, 32'hAABB_CCDD, 0};
    vecs[8]  = '{0, 3'b101, 32'h0000_0006, 32'h0,         0, 8'h01, 32'h0000_AABB, 0};
    vecs[9]  = '{1, 3'b010, 32'h0000_03FC, 32'hDEAD_BEEF, 1, 8'hFF, 32'h0,         0};
    vecs[10] = '{0, 3'b010, 32'h0000_03FC, 32'h0,         0, 8'hFF, 32'hDEAD_BEEF, 0};
    vecs[11] = '{0, 3'b010, 32'h0000_0400, 32'h0,         0, 8'h00, 32'h8070_F0A5, 0};
    vecs[12] = '{0, 3'b010, 32'h0000_0002, 32'h0,         0, 8'h00, 32'h0,         1};
    vecs[13] = '{1, 3'b001, 32'h0000_0001, 32'h1234,      0, 8'h00, 32'h0,         1};
    vecs[14] = '{0, 3'b011, 32'h0000_0000, 32'h0,         0, 8'h00, 32'h0,         1};
    vecs[15] = '{0, 3'b101, 32'h0000_0003, 32'h0,         0, 8'h00, 32'h0,         1};
    vecs[16] = '{1, 3'b100, 32'h0000_0000, 32'h55,        0, 8'h00, 32'h0,         1};
    vecs[17] = '{1, 3'b010, 32'h0000_0005, 32'h1111_2222, 0, 8'h01, 32'h0,         1};

    rst_ni = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #12;
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_wen", {31'b0, mem_write_en}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("post_rst_ready", {31'b0, req_ready}, 32'h1);
    check("idle_wen", {31'b0, mem_write_en}, 32'h0);

    // Single-transaction vectors.
    for (int i = 0; i < NumVecs; i++) begin
      @(negedge clk_i);
      drive(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("v%0d_ready", i), {31'b0, req_ready}, 32'h1);
      check($sformatf("v%0d_wen", i), {31'b0, mem_write_en}, {31'b0, vecs[i].exp_wen});
      check($sformatf("v%0d_maddr", i), {24'b0, mem_addr}, {24'b0, vecs[i].exp_maddr});
      if (vecs[i].exp_wen)
        check($sformatf("v%0d_wdata", i), mem_write_data, vecs[i].wdata);
      @(posedge clk_i); #1;
      req_valid = 1'b0;
      #1;
      check($sformatf("v%0d_rvalid", i), {31'b0, resp_valid}, 32'h1);
      check($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'b0, resp_err}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_ready_n1", i), {31'b0, req_ready}, 32'h1);
      check($sformatf("v%0d_wen_n1", i), {31'b0, mem_write_en}, 32'h0);
      @(posedge clk_i); #1;
      check($sformatf("v%0d_pulse", i), {31'b0, resp_valid}, 32'h0);
    end
    check("err_no_write_w0", mem[0], 32'h8070_F0A5);
    check("err_no_write_w1", mem[1], 32'hAABB_CCDD);

    // SB read-modify-write onto word 1.
    @(negedge clk_i);
    drive(1'b1, 3'b000, 32'h6, 32'h0000_0011);
    #1;
    check("sb_ready_n", {31'b0, req_ready}, 32'h1);
    check("sb_wen_n", {31'b0, mem_write_en}, 32'h0);
    @(posedge clk_i); #1;
    req_valid = 1'b0;
    #1;
    check("sb_ready_n1", {31'b0, req_ready}, 32'h0);
    check("sb_wen_n1", {31'b0, mem_write_en}, 32'h1);
    check("sb_maddr_n1", {24'b0, mem_addr}, 32'h1);
    check("sb_wdata_n1", mem_write_data, 32'hAA11_CCDD);
    check("sb_rvalid_n1", {31'b0, resp_valid}, 32'h0);
    @(posedge clk_i); #1;
    check("sb_rvalid_n2", {31'b0, resp_valid}, 32'h1);
    check("sb_err_n2", {31'b0, resp_err}, 32'h0);
    check("sb_rdata_n2", resp_rdata, 32'h0);
    check("sb_ready_n2", {31'b0, req_ready}, 32'h1);
    check("sb_wen_n2", {31'b0, mem_write_en}, 32'h0);
    check("sb_mem", mem[1], 32'hAA11_CCDD);
    @(posedge clk_i); #1;
    check("sb_pulse", {31'b0, resp_valid}, 32'h0);

    // SH aborted by reset during the write cycle.
    @(negedge clk_i);
    drive(1'b1, 3'b001, 32'h4, 32'h0000_1234);
    @(posedge clk_i); #1;
    req_valid = 1'b0;
    #1;
    check("abort_wen_before", {31'b0, mem_write_en}, 32'h1);
    rst_ni = 1'b0;
    #1;
    check("abort_wen", {31'b0, mem_write_en}, 32'h0);
    check("abort_ready", {31'b0, req_ready}, 32'h1);
    check("abort_rvalid", {31'b0, resp_valid}, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("abort_rvalid_after", {31'b0, resp_valid}, 32'h0);
    check("abort_ready_after", {31'b0, req_ready}, 32'h1);
    check("abort_mem", mem[1], 32'hAA11_CCDD);

    // Back-to-back SB with req_valid held through the RMW cycle.
    @(negedge clk_i);
    drive(1'b1, 3'b000, 32'h0, 32'h0000_0033);
    @(posedge clk_i); #1;
    drive(1'b1, 3'b000, 32'h1, 32'h0000_0044);
    #1;
    check("b2b_ready_rmw", {31'b0, req_ready}, 32'h0);
    check("b2b_wen_rmw1", {31'b0, mem_write_en}, 32'h1);
    check("b2b_maddr_rmw1", {24'b0, mem_addr}, 32'h0);
    check("b2b_wdata_rmw1", mem_write_data, 32'h8070_F033);
    @(posedge clk_i); #1;
    check("b2b_rvalid1", {31'b0, resp_valid}, 32'h1);
    check("b2b_ready2", {31'b0, req_ready}, 32'h1);
    check("b2b_wen_idle", {31'b0, mem_write_en}, 32'h0);
    @(posedge clk_i); #1;
    req_valid = 1'b0;
    #1;
    check("b2b_rvalid_gap", {31'b0, resp_valid}, 32'h0);
    check("b2b_wen_rmw2", {31'b0, mem_write_en}, 32'h1);
    check("b2b_wdata_rmw2", mem_write_data, 32'h8070_4433);
    @(posedge clk_i); #1;
    check("b2b_rvalid2", {31'b0, resp_valid}, 32'h1);
    check("b2b_mem", mem[0], 32'h8070_4433);
    @(posedge clk_i); #1;
    check("b2b_pulse", {31'b0, resp_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001: ADDR_WIDTH, 8, word-address width of the data memory port.
REQ-002: WIDTH, 32, data width of the memory and pipeline buses.
REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: req_valid  input  1  MEM-stage request present.
REQ-006: req_ready  output  1  request accepted in any cycle where req_valid and req_ready are both high.
REQ-007: req_we  input  1  1 = store, 0 = load.
REQ-008: req_funct3  input  3  RV32I width/sign code: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
REQ-009: req_addr  input  32  byte address.
REQ-010: req_wdata  input  WIDTH  store data; the value is taken from the low lanes.
REQ-011: resp_valid  output  1  one-cycle pulse marking request completion.
REQ-012: resp_rdata  output  WIDTH  extended load data, valid with resp_valid; 0 for stores and errors.
REQ-013: resp_err  output  1  misaligned or illegal funct3, valid with resp_valid.
REQ-014: mem_write_en  output  1  data-memory write enable.
REQ-015: mem_addr  output  ADDR_WIDTH  word address, equal to req_addr[ADDR_WIDTH+1:2]; upper address bits are ignored and wrap.
REQ-016: mem_write_data  output  WIDTH  full word to write.
REQ-017: mem_read_data  input  WIDTH  memory read word, combinational from mem_addr.

Function
REQ-018: The unit SHALL have the states IDLE and RMW_WR.
REQ-019: req_ready SHALL equal (state==IDLE).
REQ-020: A load accepted in IDLE in cycle N SHALL sample mem_read_data in cycle N, take the addressed lane, and present resp_valid=1 with resp_rdata in cycle N+1.
REQ-021: LB/LH SHALL sign-extend the loaded value; LBU/LHU SHALL zero-extend it.
REQ-022: Lane selection SHALL be: byte lane = req_addr[1:0], half lane = req_addr[1].
REQ-023: SW accepted in cycle N SHALL drive mem_write_en=1 with mem_write_data=req_wdata combinationally in cycle N, with resp_valid in cycle N+1 and no stall.
REQ-024: SB/SH accepted in cycle N SHALL read the word in cycle N and register it with the new byte or half merged into the addressed lane and all other lanes preserved.
REQ-025: After an accepted SB/SH the unit SHALL enter RMW_WR, drive mem_write_en=1, mem_write_data=merged word, and mem_addr=captured word address in cycle N+1, then return to IDLE with resp_valid in cycle N+2.
REQ-026: mem_write_en SHALL be 0 in every cycle not covered by REQ-023 and REQ-025, including IDLE with req_valid=0 and all loads.
REQ-027: A misaligned access (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0) or an illegal funct3 SHALL issue no write, return resp_valid=1, resp_err=1, resp_rdata=0 in cycle N+1, and remain in IDLE.
REQ-028: In RMW_WR, req_valid SHALL be ignored; the pipeline holds its request, and back-to-back requests resume in the cycle after RMW_WR.
REQ-029: resp_valid SHALL pulse exactly once per accepted request.

Reset
REQ-030: rst_n low SHALL immediately force state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, and all captured registers to 0.
REQ-031: A reset asserted during RMW_WR SHALL abort the write, so mem_write_en drops to 0 asynchronously, and no response SHALL be issued.
REQ-032: After rst_n deasserts, req_ready SHALL be 1 in the first cycle.

Structure
REQ-033: Package lsu_pkg SHALL hold the funct3 encodings (localparams) and the state enum typedef.
REQ-034: Combinational lane extract/extend and merge logic SHALL live in one sub-module, lsu_align, instantiated once.

Verification
REQ-035: Memory word 0x0 = 0x8070_F0A5; LB addr 0x0 -> resp_rdata 0xFFFF_FFA5; LBU addr 0x1 -> 0x0000_00F0; LH addr 0x2 -> 0xFFFF_8070, each with 1-cycle latency.
REQ-036: SB wdata 0x0000_0011 addr 0x6 onto word 0x1 = 0xAABB_CCDD -> req_ready low 1 cycle, write of 0xAA11_CCDD at mem_addr 1 in cycle N+1, resp_valid in cycle N+2.
REQ-037: SW 0xDEAD_BEEF addr 0x3FC -> mem_write_en in cycle N at mem_addr 0xFF, then LW addr 0x3FC -> 0xDEAD_BEEF.
REQ-038: LW addr 0x2, SH addr 0x1, funct3 011 -> resp_err=1, resp_rdata=0, mem_write_en never 1.
REQ-039: SH accepted, rst_n pulsed low during RMW_WR -> no write, no resp_valid, memory word unchanged, req_ready=1 after release.
REQ-040: Back-to-back SB addr 0x0, SB addr 0x1 with req_valid held -> second request accepted only after RMW_WR, final word has both bytes updated.
